icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, meaning the number of direct-mapped lines; it is fixed at 16 and the bench checks only that value.
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line; it is fixed at 4.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 cpu_addr  input  32  fetch byte address (the CPU's icache_addr).
REQ-006 cpu_re  input  1  fetch request enable.
REQ-007 cpu_dout  output  32  fetched instruction word (the CPU's icache_dout).
REQ-008 stall  output  1  high while a miss is outstanding; the CPU holds state.
REQ-009 flush  input  1  invalidate all lines.
REQ-010 mem_req_valid  output  1  line refill request.
REQ-011 mem_req_ready  input  1  memory accepts the request.
REQ-012 mem_req_addr  output  32  line-aligned refill address ({tag,index,4'b0}).
REQ-013 mem_resp_valid  input  1  refill data beat valid.
REQ-014 mem_resp_data  input  32  refill beat; beats arrive in word order 0..3.

Function
REQ-015 Address split SHALL be: offset = cpu_addr[3:2], index = cpu_addr[7:4], tag = cpu_addr[31:8]; bits [1:0] are ignored.
REQ-016 Storage SHALL be 16 lines x 4 words of data, a 24-bit tag per line, and one valid bit per line.
REQ-017 The FSM SHALL have states RUN, REQ, REFILL and REPLAY.
REQ-018 In RUN with cpu_re=1 at edge N, the address SHALL be latched and looked up; a hit drives cpu_dout with the word after edge N, and stall stays 0 (one-cycle synchronous read).
REQ-019 On a miss at edge N, the FSM SHALL go to REQ, and stall and mem_req_valid are 1 from edge N onward.
REQ-020 In REQ, mem_req_valid SHALL hold and mem_req_addr SHALL stay stable until mem_req_ready=1 is sampled; the FSM then goes to REFILL.
REQ-021 In REFILL, each mem_resp_valid beat SHALL be written into the indexed line at a 2-bit beat counter position, and the counter increments from 0 to 3 and wraps to 0.
REQ-022 After the 4th beat, the tag SHALL be written and valid set, and the FSM goes to REPLAY.
REQ-023 In REPLAY, the latched address SHALL be read, and on the next edge cpu_dout shows the requested word, stall=0, and the FSM returns to RUN.
REQ-024 While stall=1, cpu_addr and cpu_re SHALL be ignored and only the latched address is used.
REQ-025 When cpu_re=0 in RUN, no lookup SHALL occur and cpu_dout holds its value.
REQ-026 A miss SHALL evict the resident line at that index unconditionally; no dirty state exists.
REQ-027 flush=1 in RUN SHALL clear all valid bits at the edge, and a lookup in the same cycle is treated as a miss.
REQ-028 flush=1 during REQ/REFILL/REPLAY SHALL be recorded; the refill still completes and the word is returned, but valid is not set and all valid bits are cleared on entry to RUN.
REQ-029 mem_resp_valid outside REFILL SHALL be ignored.

Reset
REQ-030 On reset=0, the following SHALL clear immediately regardless of clk: state=RUN, all valid bits=0, stall=0, mem_req_valid=0, mem_req_addr=0, cpu_dout=0, beat counter=0, pending flush=0.
REQ-031 Reset asserted mid-refill SHALL abort the refill; the partial line stays invalid, and any later mem_resp_valid beats are ignored.
REQ-032 Data and tag arrays SHALL NOT need reset.

Configuration
REQ-033 With macro ICACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (32-bit each, reset to 0, wrapping) that increment on each RUN lookup hit and miss respectively.
REQ-034 Without ICACHE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Cold miss: after reset, cpu_addr=0x0000_0004 with cpu_re=1 and mem_req_ready=1 -> mem_req_addr=0x0, 4 beats 0xA0..0xA3 -> stall 1, then 0; cpu_dout=0xA1.
REQ-036 Hit after fill: cpu_addr=0x0000_000C the next cycle -> stall stays 0, cpu_dout=0xA3 one cycle later, and no mem_req_valid.
REQ-037 Conflict: fetch 0x0000_0100 -> miss with mem_req_addr=0x100; a refetch of 0x0 then misses again.
REQ-038 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable and stall=1 throughout, and REFILL starts only after ready=1.
REQ-039 Flush: flush=1 during a REFILL of 0x40 -> the word is returned, and an immediate refetch of 0x40 misses.
REQ-040 Reset mid-refill: reset=0 after 2 beats -> stall=0 and mem_req_valid=0 asynchronously; a later fetch of the same line issues a new request.

Source files
------------

// File: rtl/icache_if.sv
// icache_if: groups the CPU fetch port and the memory refill port of the
// instruction cache. The cache uses the slave modport; the fetch unit /
// memory side uses the master modport.
interface icache_if;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  cpu_addr, cpu_re, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_dout, stall, mem_req_valid, mem_req_addr
    );

    modport master (
        output cpu_addr, cpu_re, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_dout, stall, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 16 lines x 4 words of 32 bits.
// Address split: offset = addr[3:2], index = addr[7:4], tag = addr[31:8].
// A miss requests the whole line, takes 4 beats in word order, then replays
// the latched address so the CPU gets its word one cycle after the last beat.
// Optional feature: define ICACHE_STATS_EN to add hit_count / miss_count.
module icache #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_REFILL = 2'd2,
        ST_REPLAY = 2'd3
    } state_t;

    // Storage arrays carry no reset; the valid bits alone qualify them.
    logic [31:0] data_mem [NUM_LINES][WORDS_PER_LINE];
    logic [23:0] tag_mem  [NUM_LINES];

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [29:0]            waddr_q, waddr_d;   // latched word address (byte addr [31:2])
    logic [31:0]            cpu_dout_q, cpu_dout_d;
    logic                   stall_q, stall_d;
    logic                   mrv_q, mrv_d;
    logic [31:0]            mra_q, mra_d;
    logic [1:0]             beat_q, beat_d;
    logic                   pflush_q, pflush_d; // flush seen while a miss is in flight

    logic                   data_wr_s;
    logic                   tag_wr_s;
    logic                   hit_evt_s;
    logic                   miss_evt_s;

    logic [23:0]            lk_tag_s;
    logic [3:0]             lk_idx_s;
    logic [1:0]             lk_off_s;
    logic                   hit_s;

    // Byte-select bits of the fetch address carry no meaning for word fetches.
    logic                   unused_addr_bits_s;
    assign unused_addr_bits_s = ^bus.cpu_addr[1:0];

    assign lk_tag_s = bus.cpu_addr[31:8];
    assign lk_idx_s = bus.cpu_addr[7:4];
    assign lk_off_s = bus.cpu_addr[3:2];
    // A flush in the lookup cycle forces a miss.
    assign hit_s    = valid_q[lk_idx_s] && (tag_mem[lk_idx_s] == lk_tag_s) && !bus.flush;

    assign bus.cpu_dout      = cpu_dout_q;
    assign bus.stall         = stall_q;
    assign bus.mem_req_valid = mrv_q;
    assign bus.mem_req_addr  = mra_q;

    // Next-state and output computation for the lookup / refill FSM.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        waddr_d    = waddr_q;
        cpu_dout_d = cpu_dout_q;
        stall_d    = stall_q;
        mrv_d      = mrv_q;
        mra_d      = mra_q;
        beat_d     = beat_q;
        pflush_d   = pflush_q;
        data_wr_s  = 1'b0;
        tag_wr_s   = 1'b0;
        hit_evt_s  = 1'b0;
        miss_evt_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    valid_d = {NUM_LINES{1'b0}};
                end else begin
                    valid_d = valid_q;
                end
                if (bus.cpu_re) begin
                    waddr_d = bus.cpu_addr[31:2];
                    if (hit_s) begin
                        cpu_dout_d = data_mem[lk_idx_s][lk_off_s];
                        hit_evt_s  = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        stall_d    = 1'b1;
                        mrv_d      = 1'b1;
                        mra_d      = {lk_tag_s, lk_idx_s, 4'b0000};
                        beat_d     = 2'd0;
                        pflush_d   = 1'b0;
                        miss_evt_s = 1'b1;
                    end
                end else begin
                    waddr_d = waddr_q;
                end
            end
            ST_REQ: begin
                if (bus.flush) begin
                    pflush_d = 1'b1;
                end else begin
                    pflush_d = pflush_q;
                end
                if (bus.mem_req_ready) begin
                    mrv_d   = 1'b0;
                    beat_d  = 2'd0;
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REFILL: begin
                if (bus.flush) begin
                    pflush_d = 1'b1;
                end else begin
                    pflush_d = pflush_q;
                end
                if (bus.mem_resp_valid) begin
                    data_wr_s = 1'b1;
                    beat_d    = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        tag_wr_s = 1'b1;
                        state_d  = ST_REPLAY;
                        if (!pflush_q && !bus.flush) begin
                            valid_d[waddr_q[5:2]] = 1'b1;
                        end else begin
                            valid_d = valid_q;
                        end
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_REPLAY: begin
                cpu_dout_d = data_mem[waddr_q[5:2]][waddr_q[1:0]];
                stall_d    = 1'b0;
                state_d    = ST_RUN;
                pflush_d   = 1'b0;
                if (pflush_q || bus.flush) begin
                    valid_d = {NUM_LINES{1'b0}};
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                stall_d = 1'b0;
                mrv_d   = 1'b0;
            end
        endcase
    end

    // Control state, registered outputs and valid bits; reset clears all of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            valid_q    <= {NUM_LINES{1'b0}};
            waddr_q    <= 30'd0;
            cpu_dout_q <= 32'd0;
            stall_q    <= 1'b0;
            mrv_q      <= 1'b0;
            mra_q      <= 32'd0;
            beat_q     <= 2'd0;
            pflush_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            waddr_q    <= waddr_d;
            cpu_dout_q <= cpu_dout_d;
            stall_q    <= stall_d;
            mrv_q      <= mrv_d;
            mra_q      <= mra_d;
            beat_q     <= beat_d;
            pflush_q   <= pflush_d;
        end
    end

    // Refill writes into the data and tag arrays (no reset needed).
    always_ff @(posedge clk) begin
        if (data_wr_s) begin
            data_mem[waddr_q[5:2]][beat_q] <= bus.mem_resp_data;
        end
        if (tag_wr_s) begin
            tag_mem[waddr_q[5:2]] <= waddr_q[29:6];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Wrapping hit/miss counters for RUN-state lookups.
    always_comb begin
        if (hit_evt_s) begin
            hit_count_d = hit_count_q + 32'd1;
        end else begin
            hit_count_d = hit_count_q;
        end
        if (miss_evt_s) begin
            miss_count_d = miss_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. Expected fetch words are pushed
// when a fetch is issued and popped when the cache delivers the word.
module tb_icache;
    logic clk;
    logic reset;
    int   chk_cnt;
    int   err_cnt;
    logic [31:0] exp_q[$];

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory contents: line 0 holds 0xA0..0xA3, others a tagged pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] line_a, input int beat);
        if (line_a == 32'd0) return 32'h0000_00A0 + 32'(beat);
        return line_a ^ 32'h5A5A_0000 ^ 32'(beat);
    endfunction

    task automatic pop_compare(input string tag);
        logic [31:0] e;
        check_eq({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq(tag, bus.cpu_dout, e);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int ready_wait,
                         input bit flush_mid, input bit run_flush, input bit reset_mid);
        logic [31:0] line_a;
        line_a = addr & 32'hFFFF_FFF0;
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.cpu_re   = 1'b1;
        bus.flush    = run_flush;
        exp_q.push_back(mem_word(line_a, int'(addr[3:2])));
        @(negedge clk);
        bus.cpu_re   = 1'b0;
        bus.flush    = 1'b0;
        bus.cpu_addr = 32'hDEAD_BEE0;
        if (!exp_miss) begin
            check_eq("hit_stall", 32'(bus.stall), 32'd0);
            check_eq("hit_no_req", 32'(bus.mem_req_valid), 32'd0);
            pop_compare("hit_dout");
        end else begin
            check_eq("miss_stall", 32'(bus.stall), 32'd1);
            check_eq("miss_req_valid", 32'(bus.mem_req_valid), 32'd1);
            check_eq("miss_req_addr", bus.mem_req_addr, line_a);
            for (int k = 0; k < ready_wait; k++) begin
                @(negedge clk);
                check_eq("bp_req_valid", 32'(bus.mem_req_valid), 32'd1);
                check_eq("bp_req_addr", bus.mem_req_addr, line_a);
                check_eq("bp_stall", 32'(bus.stall), 32'd1);
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check_eq("req_dropped", 32'(bus.mem_req_valid), 32'd0);
            for (int i = 0; i < 4; i++) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_word(line_a, i);
                if (flush_mid && i == 1) bus.flush = 1'b1;
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
                bus.flush          = 1'b0;
                if (reset_mid && i == 1) begin
                    #2 reset = 1'b0;
                    #1;
                    check_eq("rst_stall", 32'(bus.stall), 32'd0);
                    check_eq("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
                    #1 reset = 1'b1;
                    void'(exp_q.pop_front());
                    for (int s = 0; s < 2; s++) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = 32'hBAD0_0000 + 32'(s);
                        @(negedge clk);
                    end
                    bus.mem_resp_valid = 1'b0;
                    check_eq("stray_dout", bus.cpu_dout, 32'd0);
                    check_eq("stray_stall", 32'(bus.stall), 32'd0);
                    check_eq("stray_req", 32'(bus.mem_req_valid), 32'd0);
                    return;
                end
            end
            check_eq("replay_stall", 32'(bus.stall), 32'd1);
            @(negedge clk);
            check_eq("done_stall", 32'(bus.stall), 32'd0);
            pop_compare("miss_dout");
        end
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        reset   = 1'b0;
        bus.cpu_addr       = 32'd0;
        bus.cpu_re         = 1'b0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_stall0", 32'(bus.stall), 32'd0);
        check_eq("rst_req_valid0", 32'(bus.mem_req_valid), 32'd0);
        check_eq("rst_req_addr0", bus.mem_req_addr, 32'd0);
        check_eq("rst_dout0", bus.cpu_dout, 32'd0);
        reset = 1'b1;

        // Cold miss, then hits in the same line.
        fetch(32'h0000_0004, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        fetch(32'h0000_000C, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        fetch(32'h0000_0008, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // No lookup with cpu_re low: output holds.
        @(negedge clk);
        bus.cpu_addr = 32'h0000_0004;
        repeat (2) @(negedge clk);
        check_eq("re0_hold_dout", bus.cpu_dout, 32'h0000_00A2);
        check_eq("re0_stall", 32'(bus.stall), 32'd0);

        // Conflict on index 0.
        fetch(32'h0000_0100, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        fetch(32'h0000_0000, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Backpressure for 5 cycles.
        fetch(32'h0000_0208, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        fetch(32'h0000_0204, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Flush during refill: word returned, no line survives.
        fetch(32'h0000_0040, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        fetch(32'h0000_0040, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        fetch(32'h0000_0204, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Flush in RUN turns a would-be hit into a miss.
        fetch(32'h0000_0200, 1'b1, 0, 1'b0, 1'b1, 1'b0);

        // Reset mid-refill, then the same line must be requested again.
        fetch(32'h0000_0300, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        fetch(32'h0000_0304, 1'b1, 0, 1'b0, 1'b0, 1'b0);

`ifdef ICACHE_STATS_EN
        check_eq("stat_hits", hit_count, 32'd0);
        check_eq("stat_misses", miss_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
